// File: rtl/usr_cmd_sequencer.sv
// rtl/usr_cmd_sequencer.sv - command sequencer driving a universal shift register's MODE/DATAIN
module usr_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_datain,
  input  logic [WIDTH-1:0] usr_dataout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] lat_data;
  logic             lat_dir;
  logic             lat_fill;
  logic [CNT_W-1:0] lat_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_data  <= '0;
      lat_dir   <= 1'b0;
      lat_fill  <= 1'b0;
      lat_count <= '0;
      rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && cmd_valid) begin
        lat_data  <= cmd_data;
        lat_dir   <= cmd_dir;
        lat_fill  <= cmd_fill;
        lat_count <= cmd_count;
      end
      // Register output has absorbed the load and every shift by the SETTLE cycle.
      if (state == SETTLE) begin
        rsp_data <= usr_dataout;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cmd_ready  = 1'b0;
    usr_mode   = MODE_HOLD;
    usr_datain = '0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        usr_mode   = MODE_LOAD;
        usr_datain = lat_data;
        if (lat_count != '0) begin
          state_nxt = SHIFT;
          cnt_nxt   = lat_count;
        end else begin
          state_nxt = SETTLE;
        end
      end
      SHIFT: begin
        usr_mode   = lat_dir ? MODE_LEFT : MODE_RIGHT;
        usr_datain = {WIDTH{lat_fill}};
        cnt_nxt    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// tb/tb_usr_cmd_sequencer.sv - directed scoreboard bench for usr_cmd_sequencer
module tb_usr_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       cmd_dir;
  logic       cmd_fill;
  logic [2:0] cmd_count;
  logic [1:0] usr_mode;
  logic [3:0] usr_datain;
  logic [3:0] usr_dataout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;

  logic [3:0] reg_q = 4'b0000;
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_fill   (cmd_fill),
    .cmd_count  (cmd_count),
    .usr_mode   (usr_mode),
    .usr_datain (usr_datain),
    .usr_dataout(usr_dataout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Behavioural 4-bit universal shift register downstream of the sequencer.
  always @(posedge clock) begin
    case (usr_mode)
      2'b01:   reg_q <= {usr_datain[3], reg_q[3:1]};
      2'b10:   reg_q <= {reg_q[2:0], usr_datain[0]};
      2'b11:   reg_q <= usr_datain;
      default: reg_q <= reg_q;
    endcase
  end
  assign usr_dataout = reg_q;

  function automatic logic [3:0] model(input logic [3:0] d, input logic dir, input logic fill,
                                       input int cnt);
    logic [3:0] q;
    q = d;
    for (int i = 0; i < cnt; i++) begin
      q = dir ? {q[2:0], fill} : {fill, q[3:1]};
    end
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge after the response handshake.
  task automatic run_cmd(input logic [3:0] d, input logic dir, input logic fill, input int cnt,
                         input int hold, input bit early, input bit has_next,
                         input logic [3:0] nd, input logic ndir, input logic nfill, input int ncnt);
    logic [3:0] held;
    logic [3:0] exp;
    logic [1:0] smode;
    smode     = dir ? 2'b10 : 2'b01;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_fill  = fill;
    cmd_count = 3'(cnt);
    cmd_valid = 1'b1;
    rsp_ready = early;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    exp_q.push_back(model(d, dir, fill, cnt));
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k <= cnt + 1; k++) begin
      if (k == 0) begin
        check("mode_load", 32'(usr_mode), 32'(2'b11));
        check("datain_load", 32'(usr_datain), 32'(d));
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      end else if (k <= cnt) begin
        check("mode_shift", 32'(usr_mode), 32'(smode));
        check("datain_shift", 32'(usr_datain), 32'({4{fill}}));
      end else begin
        check("mode_settle", 32'(usr_mode), 32'(2'b00));
      end
      check("rsp_valid_early", 32'(rsp_valid), 32'd0);
      check("busy_active", 32'(busy), 32'd1);
      @(negedge clock);
    end
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    check("mode_resp", 32'(usr_mode), 32'(2'b00));
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (has_next) begin
        cmd_data  = nd;
        cmd_dir   = ndir;
        cmd_fill  = nfill;
        cmd_count = 3'(ncnt);
        cmd_valid = 1'b1;
      end
      @(negedge clock);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'(held));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    check("rsp_data", 32'(rsp_data), 32'(exp));
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 4'h0;
    cmd_dir   = 1'b0;
    cmd_fill  = 1'b0;
    cmd_count = 3'd0;
    rsp_ready = 1'b0;
    #20;
    reset = 1'b1;
    @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mode", 32'(usr_mode), 32'd0);
    check("rst_datain", 32'(usr_datain), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    run_cmd(4'b1011, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    run_cmd(4'b0011, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    run_cmd(4'b1010, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    run_cmd(4'b1100, 1'b1, 1'b0, 3, 5, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, 2);
    run_cmd(4'b0101, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    run_cmd(4'b1001, 1'b1, 1'b0, 7, 2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);

    // Abort a count-7 command during its third shift cycle.
    cmd_data  = 4'b1110;
    cmd_dir   = 1'b0;
    cmd_fill  = 1'b1;
    cmd_count = 3'd7;
    cmd_valid = 1'b1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_in_shift", 32'(usr_mode), 32'(2'b01));
    #2;
    reset = 1'b0;
    #1;
    check("abort_cmd_ready_now", 32'(cmd_ready), 32'd1);
    check("abort_mode_now", 32'(usr_mode), 32'd0);
    check("abort_datain_now", 32'(usr_datain), 32'd0);
    check("abort_busy_now", 32'(busy), 32'd0);
    check("abort_rsp_valid_now", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data_now", 32'(rsp_data), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    run_cmd(4'b0110, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
- Command-driven control stage directly upstream of the 4-bit universal shift register.
- Accepts one command per transaction over a valid/ready handshake: load value, shift direction, shift count and fill bit.
- Drives the register's MODE/DATAIN cycle by cycle, then captures the register's DATAOUT and returns it as a response over a second valid/ready handshake.
- Lets higher-level logic issue "load and shift N" operations without hand-sequencing MODE.

Parameters:
- WIDTH, 4, data width; matches the shift register width.
- CNT_W, 3, width of the shift count; maximum count is 2^CNT_W-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_data  input  WIDTH  parallel value to load.
- cmd_dir  input  1  0 = shift right, 1 = shift left.
- cmd_fill  input  1  serial fill bit shifted in.
- cmd_count  input  CNT_W  number of shift cycles after the load.
- usr_mode  output  2  drives the register's MODE.
- usr_datain  output  WIDTH  drives the register's DATAIN.
- usr_dataout  input  WIDTH  the register's DATAOUT.
- rsp_valid  output  1  rsp_data is valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  captured register value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- MODE encoding (register contract):
  - 00 = hold.
  - 01 = shift right: q <= {DATAIN[WIDTH-1], q[WIDTH-1:1]}.
  - 10 = shift left: q <= {q[WIDTH-2:0], DATAIN[0]}.
  - 11 = parallel load: q <= DATAIN.
- Reset values (reset=0, immediate, asynchronous):
  - state = IDLE; cmd_ready = 1; usr_mode = 00; usr_datain = 0.
  - rsp_valid = 0; rsp_data = 0; busy = 0; internal counter and latched command fields = 0.
- FSM states: IDLE, LOAD, SHIFT, SETTLE, RESP. All outputs are registered or decoded from registered state; no combinational path from cmd_* to usr_*.
- IDLE:
  - cmd_ready = 1; usr_mode = 00; usr_datain = 0.
  - On cmd_valid & cmd_ready at a clock edge: latch data, dir, fill, count; go to LOAD.
- LOAD (1 cycle):
  - usr_mode = 11; usr_datain = latched data.
  - Next state is SHIFT with counter = count if count != 0; otherwise SETTLE.
- SHIFT (exactly count cycles):
  - usr_mode = 01 (dir=0) or 10 (dir=1); usr_datain = fill replicated across WIDTH.
  - Counter decrements each cycle; when counter == 1, next state is SETTLE.
- SETTLE (1 cycle):
  - usr_mode = 00; usr_datain = 0.
  - At the end of this cycle, rsp_data <= usr_dataout and state moves to RESP.
- RESP:
  - rsp_valid = 1; rsp_data stable; usr_mode = 00.
  - On rsp_ready, rsp_valid drops at the next edge and state returns to IDLE.
  - rsp_valid holds indefinitely while rsp_ready = 0.
- cmd_ready = 0 in every state except IDLE; commands presented while busy are not accepted and must be held by the source.
- Latency: from the command-accept edge to rsp_valid rising is count+2 clock edges. Back-to-back commands: a new command may be accepted in IDLE on the cycle after the response handshake; there is no overlap.
- Boundary conditions:
  - count = 0 gives load only; rsp_data = cmd_data.
  - count = 2^CNT_W-1 is supported; the counter never wraps.
  - rsp_ready asserted before RESP is ignored.
- Reset asserted mid-operation (any state) forces the reset values immediately. A pending response is discarded and no partial response is emitted.
- After reset deasserts, the first accepted command behaves exactly as after power-up.

Test Plan:
- Reset then idle: hold reset=0 for 20 ns, release -> cmd_ready=1, usr_mode=00, rsp_valid=0, busy=0.
- Load and shift right: cmd_data=1011, dir=0, fill=0, count=1 -> usr_mode sequence 11,01,00; rsp_data=0101; rsp_valid rises 3 edges after accept.
- Load and shift left with fill: cmd_data=0011, dir=1, fill=1, count=2 -> usr_mode sequence 11,10,10,00; rsp_data=1111.
- Count zero: cmd_data=1010, count=0 -> usr_mode sequence 11,00; rsp_data=1010; rsp_valid rises 2 edges after accept.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable; cmd_ready=0 while cmd_valid is held high; a second command is accepted only after the rsp handshake.
- Reset mid-shift: cmd count=7; assert reset during the 3rd SHIFT cycle -> outputs return to reset values at once with no rsp_valid pulse; a subsequent command (0110, dir=0, count=1, fill=1) returns 1011.
